// File: rtl/int8_vec_packer_pkg.sv
// ---------------------------------------------------------------------------
// int8_vec_packer_pkg
// Shared constants and types for the int8 operand vector packer.
//   INT8_LANES  : default number of lanes per output vector
//   INT8_W      : width of one signed int8 operand
//   INT8_VEC_W  : width of one packed operand vector
//   LANE_CNT_W  : width of the lane index / populated-lane count
//   pack_state_t: packer control state (FILL accepting, HOLD stalled)
// ---------------------------------------------------------------------------
package int8_vec_packer_pkg;

    localparam int INT8_LANES = 33;
    localparam int INT8_W     = 8;
    localparam int INT8_VEC_W = INT8_LANES * INT8_W;
    localparam int LANE_CNT_W = 6;

    typedef enum logic {
        FILL = 1'b0,
        HOLD = 1'b1
    } pack_state_t;

endpackage

// File: rtl/int8_lane_buffer.sv
// ---------------------------------------------------------------------------
// int8_lane_buffer
// NUM-lane fill register for operand pairs. A pair is written into the lane
// selected by wr_idx. The merged outputs show the buffer contents with the
// pair being written this cycle already applied, so the closing pair of a
// vector is visible in the same cycle it arrives. On clear the buffer
// returns to all zeros, which makes the tail of the next vector zero-padded.
// Ports:
//   clk, rst          : clock, asynchronous active-high reset
//   wr_en             : write the pair (wr_a, wr_b) into lane wr_idx
//   wr_idx            : target lane
//   wr_a, wr_b        : operand bytes
//   clear             : zero the buffer (takes priority over wr_en)
//   merged_a/merged_b : buffer contents with the current write merged in
// ---------------------------------------------------------------------------
module int8_lane_buffer
    import int8_vec_packer_pkg::*;
#(
    parameter int NUM = INT8_LANES
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    wr_en,
    input  logic [LANE_CNT_W-1:0]   wr_idx,
    input  logic [INT8_W-1:0]       wr_a,
    input  logic [INT8_W-1:0]       wr_b,
    input  logic                    clear,
    output logic [NUM*INT8_W-1:0]   merged_a,
    output logic [NUM*INT8_W-1:0]   merged_b
);

    logic [NUM*INT8_W-1:0] buf_a;
    logic [NUM*INT8_W-1:0] buf_b;

    // Overlay the incoming pair on its lane; other lanes come from the buffer.
    always_comb begin
        merged_a = buf_a;
        merged_b = buf_b;
        if (wr_en) begin
            for (int i = 0; i < NUM; i++) begin
                if (wr_idx == LANE_CNT_W'(i)) begin
                    merged_a[i*INT8_W +: INT8_W] = wr_a;
                    merged_b[i*INT8_W +: INT8_W] = wr_b;
                end
            end
        end
    end

    // Clear wins over write: the closing pair lives only in the emitted
    // vector, never in the buffer that starts the next one.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            buf_a <= '0;
            buf_b <= '0;
        end else if (clear) begin
            buf_a <= '0;
            buf_b <= '0;
        end else if (wr_en) begin
            buf_a <= merged_a;
            buf_b <= merged_b;
        end
    end

endmodule

// File: rtl/int8_vec_packer.sv
// ---------------------------------------------------------------------------
// int8_vec_packer
// Packs a serial stream of signed int8 operand pairs into NUM-lane vectors
// for the int8 dot-product MAC. Each dot product ends with an in_last pair;
// its final vector is zero-padded above the last populated lane. Vectors are
// presented on a valid/ready interface tagged with first/last so the MAC can
// zero its partial sum and know when to capture the result.
// Ports:
//   clk, rst          : clock, asynchronous active-high reset
//   in_valid/in_ready : input handshake (in_ready is registered)
//   in_a, in_b        : operand bytes, passed bit-exact
//   in_last           : pair ends the current dot product
//   out_valid/out_ready : output handshake
//   a_vec, b_vec      : packed lanes, lane 0 in the LSBs
//   out_first         : first vector of a dot product
//   out_last          : final vector of a dot product
//   out_lanes         : populated lanes in this vector, 1..NUM
//   dp_count          : completed dot products, wraps modulo 2^CNT_W
// ---------------------------------------------------------------------------
module int8_vec_packer
    import int8_vec_packer_pkg::*;
#(
    parameter int NUM   = INT8_LANES,
    parameter int CNT_W = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [INT8_W-1:0]       in_a,
    input  logic [INT8_W-1:0]       in_b,
    input  logic                    in_last,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [NUM*INT8_W-1:0]   a_vec,
    output logic [NUM*INT8_W-1:0]   b_vec,
    output logic                    out_first,
    output logic                    out_last,
    output logic [LANE_CNT_W-1:0]   out_lanes,
    output logic [CNT_W-1:0]        dp_count
);

    localparam int VEC_W = NUM * INT8_W;

    pack_state_t            state;
    pack_state_t            state_next;

    logic [LANE_CNT_W-1:0]  fill_idx;
    logic                   first_pending;

    logic                   accept;
    logic                   close;
    logic                   slot_free;
    logic                   out_fire;
    logic                   load_new;
    logic                   load_held;
    logic                   capture_hold;

    logic [VEC_W-1:0]       closed_a;
    logic [VEC_W-1:0]       closed_b;
    logic [LANE_CNT_W-1:0]  closed_lanes;

    logic [VEC_W-1:0]       held_a;
    logic [VEC_W-1:0]       held_b;
    logic                   held_first;
    logic                   held_last;
    logic [LANE_CNT_W-1:0]  held_lanes;

    assign accept       = in_valid && in_ready;
    assign close        = accept && ((fill_idx == LANE_CNT_W'(NUM - 1)) || in_last);
    assign slot_free    = !out_valid || out_ready;
    assign out_fire     = out_valid && out_ready;
    assign closed_lanes = fill_idx + LANE_CNT_W'(1);

    int8_lane_buffer #(
        .NUM      (NUM)
    ) u_lane_buffer (
        .clk      (clk),
        .rst      (rst),
        .wr_en    (accept),
        .wr_idx   (fill_idx),
        .wr_a     (in_a),
        .wr_b     (in_b),
        .clear    (close),
        .merged_a (closed_a),
        .merged_b (closed_b)
    );

    // Next-state and load decisions. A closed vector goes straight to the
    // output registers when the slot frees up this cycle; otherwise it is
    // parked in the hold registers and input is stopped until it drains.
    always_comb begin
        state_next   = state;
        load_new     = 1'b0;
        load_held    = 1'b0;
        capture_hold = 1'b0;
        case (state)
            FILL: begin
                if (close) begin
                    if (slot_free) begin
                        load_new = 1'b1;
                    end else begin
                        capture_hold = 1'b1;
                        state_next   = HOLD;
                    end
                end
            end
            HOLD: begin
                if (out_fire) begin
                    load_held  = 1'b1;
                    state_next = FILL;
                end
            end
            default: state_next = FILL;
        endcase
    end

    // Control state plus registered in_ready, which simply mirrors whether
    // the packer will be in FILL next cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= FILL;
            in_ready <= 1'b1;
        end else begin
            state    <= state_next;
            in_ready <= (state_next == FILL);
        end
    end

    // Fill position and dot-product boundary tracking. first_pending marks
    // that the next vector starts a new dot product.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fill_idx      <= '0;
            first_pending <= 1'b1;
        end else if (close) begin
            fill_idx      <= '0;
            first_pending <= in_last;
        end else if (accept) begin
            fill_idx      <= fill_idx + LANE_CNT_W'(1);
        end
    end

    // Single-entry overflow store for a vector that closed while the output
    // was stalled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            held_a     <= '0;
            held_b     <= '0;
            held_first <= 1'b0;
            held_last  <= 1'b0;
            held_lanes <= '0;
        end else if (capture_hold) begin
            held_a     <= closed_a;
            held_b     <= closed_b;
            held_first <= first_pending;
            held_last  <= in_last;
            held_lanes <= closed_lanes;
        end
    end

    // Output register. Fields only change on a load, so everything stays
    // stable while out_valid is high and the consumer is not ready.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            a_vec     <= '0;
            b_vec     <= '0;
            out_first <= 1'b0;
            out_last  <= 1'b0;
            out_lanes <= '0;
        end else if (load_new) begin
            out_valid <= 1'b1;
            a_vec     <= closed_a;
            b_vec     <= closed_b;
            out_first <= first_pending;
            out_last  <= in_last;
            out_lanes <= closed_lanes;
        end else if (load_held) begin
            out_valid <= 1'b1;
            a_vec     <= held_a;
            b_vec     <= held_b;
            out_first <= held_first;
            out_last  <= held_last;
            out_lanes <= held_lanes;
        end else if (out_fire) begin
            out_valid <= 1'b0;
        end
    end

    // Completed dot products, counted when the final vector is taken.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dp_count <= '0;
        end else if (out_fire && out_last) begin
            dp_count <= dp_count + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_int8_vec_packer.sv
// ---------------------------------------------------------------------------
// tb_int8_vec_packer
// Directed bench for int8_vec_packer with hand-computed expected vectors.
// The DUT is built with CNT_W=2 so the dp_count wrap is reachable quickly.
// ---------------------------------------------------------------------------
module tb_int8_vec_packer;

    localparam int NUM   = 33;
    localparam int VW    = NUM * 8;
    localparam int CNT_W = 2;

    logic            clk;
    logic            rst;
    logic            in_valid;
    logic            in_ready;
    logic [7:0]      in_a;
    logic [7:0]      in_b;
    logic            in_last;
    logic            out_valid;
    logic            out_ready;
    logic [VW-1:0]   a_vec;
    logic [VW-1:0]   b_vec;
    logic            out_first;
    logic            out_last;
    logic [5:0]      out_lanes;
    logic [CNT_W-1:0] dp_count;

    typedef struct {
        logic [VW-1:0] a;
        logic [VW-1:0] b;
        logic          first;
        logic          last;
        logic [5:0]    lanes;
    } vec_t;

    vec_t got_q[$];

    int vectors_applied = 0;
    int miscompares     = 0;

    int8_vec_packer #(
        .NUM       (NUM),
        .CNT_W     (CNT_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .a_vec     (a_vec),
        .b_vec     (b_vec),
        .out_first (out_first),
        .out_last  (out_last),
        .out_lanes (out_lanes),
        .dp_count  (dp_count)
    );

    // Free-running clock, rising edges at 5, 15, 25, ...
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Capture every vector that will be accepted on the coming rising edge.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            got_q.push_back('{a: a_vec, b: b_vec, first: out_first,
                              last: out_last, lanes: out_lanes});
        end
    end

    task automatic checkOutput(input string tag, input logic [VW-1:0] got,
                               input logic [VW-1:0] exp);
        vectors_applied++;
        if (got !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        in_last  = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic doReset();
        rst = 1'b1;
        in_valid = 1'b0;
        in_last  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        got_q.delete();
        @(posedge clk);
        #1;
    endtask

    // Present one pair and return just after the edge that accepts it.
    task automatic applyStimulus(input logic [7:0] a, input logic [7:0] b,
                                 input logic last);
        int waits;
        waits    = 0;
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        in_last  = last;
        while (!in_ready && waits < 200) begin
            @(posedge clk);
            #1;
            waits++;
        end
        if (!in_ready) begin
            checkOutput("in_ready_timeout", VW'(0), VW'(1));
            in_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
    endtask

    // Wait (bounded) for n captured vectors, then confirm no extras follow.
    task automatic waitVectors(input string tag, input int n);
        int waits;
        waits = 0;
        while (got_q.size() < n && waits < 100) begin
            @(posedge clk);
            #1;
            waits++;
        end
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        checkOutput(tag, VW'(got_q.size()), VW'(n));
    endtask

    task automatic expectVec(input string tag, input logic [VW-1:0] ea,
                             input logic [VW-1:0] eb, input logic ef,
                             input logic el, input logic [5:0] en);
        vec_t v;
        if (got_q.size() == 0) begin
            checkOutput({tag, "_missing"}, VW'(0), VW'(1));
            return;
        end
        v = got_q.pop_front();
        checkOutput({tag, "_a"},     v.a,         ea);
        checkOutput({tag, "_b"},     v.b,         eb);
        checkOutput({tag, "_first"}, VW'(v.first), VW'(ef));
        checkOutput({tag, "_last"},  VW'(v.last),  VW'(el));
        checkOutput({tag, "_lanes"}, VW'(v.lanes), VW'(en));
    endtask

    logic [VW-1:0] ea;
    logic [VW-1:0] eb;
    logic [VW-1:0] ea2;
    logic [VW-1:0] eb2;
    logic [CNT_W-1:0] dp_exp [5];

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_a      = 8'h00;
        in_b      = 8'h00;
        in_last   = 1'b0;
        out_ready = 1'b1;
        #2;

        // ---- reset values while rst is held ----
        checkOutput("rst_out_valid", VW'(out_valid), VW'(0));
        checkOutput("rst_in_ready",  VW'(in_ready),  VW'(1));
        checkOutput("rst_a_vec",     a_vec,          VW'(0));
        checkOutput("rst_b_vec",     b_vec,          VW'(0));
        checkOutput("rst_lanes",     VW'(out_lanes), VW'(0));
        checkOutput("rst_dp",        VW'(dp_count),  VW'(0));
        doReset();

        // ---- 33 pairs a=i, b=-i, last on the 33rd: one full vector ----
        $display("[TB] full single vector");
        for (int i = 0; i < NUM; i++) begin
            applyStimulus(8'(i), 8'(-i), (i == NUM - 1));
            if (i == NUM - 2) checkOutput("t1_no_early_valid", VW'(out_valid), VW'(0));
        end
        checkOutput("t1_latency_valid", VW'(out_valid), VW'(1));
        idle(1);
        ea = '0;
        eb = '0;
        for (int i = 0; i < NUM; i++) begin
            ea[i*8 +: 8] = 8'(i);
            eb[i*8 +: 8] = 8'(-i);
        end
        waitVectors("t1_count", 1);
        expectVec("t1", ea, eb, 1'b1, 1'b1, 6'd33);
        checkOutput("t1_dp", VW'(dp_count), VW'(1));

        // ---- 70 pairs of (1,2): vectors of 33, 33 and 4 lanes ----
        $display("[TB] multi-vector dot product");
        doReset();
        for (int i = 0; i < 70; i++) applyStimulus(8'd1, 8'd2, (i == 69));
        idle(1);
        waitVectors("t2_count", 3);
        ea = '0;
        eb = '0;
        for (int i = 0; i < NUM; i++) begin
            ea[i*8 +: 8] = 8'd1;
            eb[i*8 +: 8] = 8'd2;
        end
        expectVec("t2_v1", ea, eb, 1'b1, 1'b0, 6'd33);
        expectVec("t2_v2", ea, eb, 1'b0, 1'b0, 6'd33);
        ea = '0;
        eb = '0;
        for (int i = 0; i < 4; i++) begin
            ea[i*8 +: 8] = 8'd1;
            eb[i*8 +: 8] = 8'd2;
        end
        expectVec("t2_v3", ea, eb, 1'b0, 1'b1, 6'd4);
        checkOutput("t2_dp", VW'(dp_count), VW'(1));

        // ---- single-lane dot products, extreme byte values ----
        $display("[TB] single-lane vectors");
        doReset();
        applyStimulus(8'h80, 8'h7F, 1'b1);
        applyStimulus(8'h05, 8'h06, 1'b1);
        idle(1);
        waitVectors("t3_count", 2);
        ea = '0;
        eb = '0;
        ea[7:0] = 8'h80;
        eb[7:0] = 8'h7F;
        expectVec("t3_v1", ea, eb, 1'b1, 1'b1, 6'd1);
        ea[7:0] = 8'h05;
        eb[7:0] = 8'h06;
        expectVec("t3_v2", ea, eb, 1'b1, 1'b1, 6'd1);
        checkOutput("t3_dp", VW'(dp_count), VW'(2));

        // ---- output stall over 66 pairs, then release ----
        $display("[TB] output stall");
        doReset();
        out_ready = 1'b0;
        ea  = '0;
        eb  = '0;
        ea2 = '0;
        eb2 = '0;
        for (int i = 0; i < NUM; i++) begin
            ea[i*8 +: 8]  = 8'(i);
            eb[i*8 +: 8]  = 8'(i + 100);
            ea2[i*8 +: 8] = 8'(i + NUM);
            eb2[i*8 +: 8] = 8'(i + NUM + 100);
        end
        for (int j = 0; j < 66; j++) begin
            applyStimulus(8'(j), 8'(j + 100), (j == 65));
            if (j == 64) checkOutput("t4_ready_before", VW'(in_ready), VW'(1));
        end
        checkOutput("t4_ready_drop", VW'(in_ready), VW'(0));
        idle(0);
        for (int c = 0; c < 5; c++) begin
            idle(1);
            checkOutput("t4_stall_valid", VW'(out_valid), VW'(1));
            checkOutput("t4_stall_a",     a_vec,          ea);
            checkOutput("t4_stall_lanes", VW'(out_lanes), VW'(33));
        end
        checkOutput("t4_stall_ready", VW'(in_ready), VW'(0));
        out_ready = 1'b1;
        idle(1);
        checkOutput("t4_b2b_valid", VW'(out_valid), VW'(1));
        checkOutput("t4_b2b_a",     a_vec,          ea2);
        waitVectors("t4_count", 2);
        expectVec("t4_v1", ea,  eb,  1'b1, 1'b0, 6'd33);
        expectVec("t4_v2", ea2, eb2, 1'b0, 1'b1, 6'd33);
        checkOutput("t4_ready_back", VW'(in_ready), VW'(1));
        checkOutput("t4_dp",         VW'(dp_count), VW'(1));

        // ---- reset in the middle of an open dot product ----
        $display("[TB] mid-stream reset");
        doReset();
        for (int i = 0; i < 10; i++) applyStimulus(8'h55, 8'h66, 1'b0);
        idle(1);
        checkOutput("t5_no_partial", VW'(out_valid), VW'(0));
        doReset();
        checkOutput("t5_rst_ready", VW'(in_ready), VW'(1));
        for (int i = 0; i < 5; i++) applyStimulus(8'(8'h10 + i), 8'(8'h20 + i), (i == 4));
        idle(1);
        waitVectors("t5_count", 1);
        ea = '0;
        eb = '0;
        for (int i = 0; i < 5; i++) begin
            ea[i*8 +: 8] = 8'(8'h10 + i);
            eb[i*8 +: 8] = 8'(8'h20 + i);
        end
        expectVec("t5", ea, eb, 1'b1, 1'b1, 6'd5);

        // ---- dp_count wrap with a 2-bit counter ----
        $display("[TB] dp_count wrap");
        doReset();
        dp_exp[0] = 2'd1;
        dp_exp[1] = 2'd2;
        dp_exp[2] = 2'd3;
        dp_exp[3] = 2'd0;
        dp_exp[4] = 2'd1;
        for (int k = 0; k < 5; k++) begin
            applyStimulus(8'(k), 8'(k), 1'b1);
            idle(3);
            checkOutput($sformatf("t6_dp%0d", k), VW'(dp_count), VW'(dp_exp[k]));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors_applied, miscompares);
        $finish;
    end

endmodule
